io_control_unit: RTL

Hardwired control sequencer for the CPU datapath. It drives the fetch cycle (T0–T2) and executes `in`, `out`, `mfhi`, `mflo`, `nop` and `halt` in T3, replacing hand-driven control signals in system-level benches. It sits beside the datapath inside `System`, reads the IR opcode field and outputs the register-transfer strobes.

---
 rtl/io_control_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/io_control_unit.sv
// Hardwired fetch/execute sequencer for the CPU datapath (T0-T2 fetch, T3 execute of in/out/mfhi/mflo/nop/halt).
// Define IO_HANDSHAKE_EN to make `in` wait for inport_strobe before transferring and retiring.
module io_control_unit #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 clear,
  input  logic                 stop,
  input  logic [4:0]           ir_opcode,
  input  logic                 inport_strobe,
  output logic                 PCout,
  output logic                 IncPC,
  output logic                 MARin,
  output logic                 Zin,
  output logic                 Zlo_out,
  output logic                 PCin,
  output logic                 MDRin,
  output logic                 Mem_read,
  output logic                 Mem_enable512x32,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Gra,
  output logic                 Rin,
  output logic                 Rout,
  output logic                 outport_in,
  output logic                 Inport_out,
  output logic                 HIout,
  output logic                 LOout,
  output logic                 run,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_IN_WAIT,
    S_HALTED
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   retire;
  logic                   in_ready;

`ifdef IO_HANDSHAKE_EN
  assign in_ready = inport_strobe;
`else
  logic unused_inport_strobe;
  assign unused_inport_strobe = inport_strobe;
  assign in_ready = 1'b1;
`endif

  always_ff @(posedge Clock) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_RST:  if (!stop) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (ir_opcode == OP_HALT) begin
          state_d = S_HALTED;
        end else if (ir_opcode == OP_IN && !in_ready) begin
          state_d = S_IN_WAIT;
        end else begin
          retire  = 1'b1;
          state_d = stop ? S_RST : S_T0;
        end
      end
      S_IN_WAIT: begin
        if (in_ready) begin
          retire  = 1'b1;
          state_d = stop ? S_RST : S_T0;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RST;
    endcase
    // clear overrides everything, including a retiring transfer in the same cycle
    if (clear) state_d = S_RST;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (retire) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_comb begin
    PCout            = 1'b0;
    IncPC            = 1'b0;
    MARin            = 1'b0;
    Zin              = 1'b0;
    Zlo_out          = 1'b0;
    PCin             = 1'b0;
    MDRin            = 1'b0;
    Mem_read         = 1'b0;
    Mem_enable512x32 = 1'b0;
    MDRout           = 1'b0;
    IRin             = 1'b0;
    Gra              = 1'b0;
    Rin              = 1'b0;
    Rout             = 1'b0;
    outport_in       = 1'b0;
    Inport_out       = 1'b0;
    HIout            = 1'b0;
    LOout            = 1'b0;
    illegal_op       = 1'b0;
    run              = (state_q != S_HALTED);
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        IncPC = 1'b1;
        MARin = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlo_out          = 1'b1;
        PCin             = 1'b1;
        MDRin            = 1'b1;
        Mem_read         = 1'b1;
        Mem_enable512x32 = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3, S_IN_WAIT: begin
        case (ir_opcode)
          OP_OUT: begin
            Gra        = 1'b1;
            Rout       = 1'b1;
            outport_in = 1'b1;
          end
          OP_IN: begin
            Gra        = in_ready;
            Rin        = in_ready;
            Inport_out = in_ready;
          end
          OP_MFHI: begin
            Gra   = 1'b1;
            Rin   = 1'b1;
            HIout = 1'b1;
          end
          OP_MFLO: begin
            Gra   = 1'b1;
            Rin   = 1'b1;
            LOout = 1'b1;
          end
          OP_NOP, OP_HALT: ;
          default: illegal_op = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  assign instr_count = cnt_q;

endmodule
